one_to_two_distributor_32bit: RTL

Registered 1-to-2 data distributor for the multicycle datapath. It is the write-side counterpart of the 32-bit two-input selector. A single producer word is steered by `Control` into one of two destination queues: `Control`=0 selects Zero, `Control`=1 selects One. Each queue drains independently through a valid/ready handshake. The block sits between a shared result source (ALU/memory read path) and two consumers that cannot always accept in the same cycle.

---
 rtl/one_to_two_distributor_32bit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/one_to_two_distributor_32bit.sv
// Registered 1-to-2 distributor: one producer word is steered by Control into
// one of two independent circular queues, each drained by its own valid/ready.
module one_to_two_distributor_32bit_lane #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNTW-1:0]  count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      occ_q, occ_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             pop;

  assign valid_o = (occ_q != '0);
  assign full_o  = (occ_q == (PW+1)'(DEPTH));
  assign pop     = valid_o && ready_i;
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q;
    cnt_d = cnt_q;
    if (push_i) begin
      wr_d  = wr_q + PW'(1);
      cnt_d = cnt_q + CNTW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    // push is only possible when not full, so a concurrent push/pop never overflows
    case ({push_i, pop})
      2'b10:   occ_d = occ_q + (PW+1)'(1);
      2'b01:   occ_d = occ_q - (PW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage survives reset; only the bookkeeping is cleared.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
endmodule

module one_to_two_distributor_32bit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNTW  = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] DataInput,
  input  logic             Control,
  input  logic             InputValid,
  output logic             InputReady,
  output logic [WIDTH-1:0] ZeroOutput,
  output logic             ZeroValid,
  input  logic             ZeroReady,
  output logic [WIDTH-1:0] OneOutput,
  output logic             OneValid,
  input  logic             OneReady,
  output logic [CNTW-1:0]  ZeroCount,
  output logic [CNTW-1:0]  OneCount
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]            push, full, valid, rdy;
  logic [NUM_LANES-1:0][WIDTH-1:0] dout;
  logic [NUM_LANES-1:0][CNTW-1:0]  cnt;
  logic                            accept;

  assign InputReady = !Reset && (Control ? !full[1] : !full[0]);
  assign accept     = InputValid && InputReady;
  assign rdy        = {OneReady, ZeroReady};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign push[g] = accept && ((g == 0) ? !Control : Control);

    one_to_two_distributor_32bit_lane #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)
    ) u_lane (
      .clk_i   (CLK),
      .rst_i   (Reset),
      .push_i  (push[g]),
      .data_i  (DataInput),
      .ready_i (rdy[g]),
      .full_o  (full[g]),
      .valid_o (valid[g]),
      .data_o  (dout[g]),
      .count_o (cnt[g])
    );
  end

  assign ZeroOutput = dout[0];
  assign OneOutput  = dout[1];
  assign ZeroValid  = valid[0];
  assign OneValid   = valid[1];
  assign ZeroCount  = cnt[0];
  assign OneCount   = cnt[1];
endmodule
